// File: rtl/tt_query_arbiter_pkg.sv
// Shared constants for the TT query arbiter: field widths, cost encoding and FSM state codes.
package tt_query_arbiter_pkg;

  localparam int unsigned COST_W = 4;
  localparam int unsigned NODE_W = 4;

  localparam logic [COST_W-1:0] COST_UNREACHABLE = '0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;

endpackage

// File: rtl/tt_query_arbiter_if.sv
// Requester, engine and response signals of the TT query arbiter.
// The arbiter uses the slave modport; the requesters and engine side use master.
interface tt_query_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT_W = 8
) ();

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned NODE_W = tt_query_arbiter_pkg::NODE_W;
  localparam int unsigned COST_W = tt_query_arbiter_pkg::COST_W;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [NODE_W*N_REQ-1:0] req_src;
  logic [NODE_W*N_REQ-1:0] req_dst;
  logic [N_REQ-1:0]        req_ready;

  logic                    eng_in_valid;
  logic [NODE_W-1:0]       eng_source;
  logic [NODE_W-1:0]       eng_destination;
  logic                    eng_out_valid;
  logic [COST_W-1:0]       eng_cost;

  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [COST_W-1:0]       rsp_cost;
  logic [LAT_W-1:0]        rsp_latency;
  logic                    busy;
  logic                    err_spurious;

  modport slave (
    input  req_valid, req_last, req_src, req_dst, eng_out_valid, eng_cost,
    output req_ready, eng_in_valid, eng_source, eng_destination,
           rsp_valid, rsp_id, rsp_cost, rsp_latency, busy, err_spurious
  );

  modport master (
    output req_valid, req_last, req_src, req_dst, eng_out_valid, eng_cost,
    input  req_ready, eng_in_valid, eng_source, eng_destination,
           rsp_valid, rsp_id, rsp_cost, rsp_latency, busy, err_spurious
  );

endinterface

// File: rtl/tt_query_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching from i_ptr upward with wrap.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx
);

  logic            w_found;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_pos;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // One extra bit holds ptr + k before the modulo-N_REQ wrap.
      w_sum = {1'b0, i_ptr} + (ID_W + 1)'(k);
      if (w_sum >= (ID_W + 1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W + 1)'(N_REQ);
      end
      w_pos = w_sum[ID_W-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/tt_query_arbiter.sv
// Shares one TT shortest-path engine among N_REQ streaming requesters, round-robin,
// and returns each result tagged with the owner id and grant-to-result latency.
module tt_query_arbiter
  import tt_query_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ),
  parameter int unsigned LAT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tt_query_arbiter_if.slave       bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_gnt;
  logic [ID_W-1:0]   r_rr;
  logic [LAT_W-1:0]  r_lat;

  logic              r_eng_in_valid;
  logic [NODE_W-1:0] r_eng_src;
  logic [NODE_W-1:0] r_eng_dst;

  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [COST_W-1:0] r_rsp_cost;
  logic [LAT_W-1:0]  r_rsp_lat;
  logic              r_err;

  logic [N_REQ-1:0]  w_arb_gnt;
  logic [ID_W-1:0]   w_arb_idx;
  logic              w_any;
  logic              w_cur_valid;
  logic              w_cur_last;
  logic              w_accept;
  logic [N_REQ-1:0]  w_req_ready;
  logic [NODE_W-1:0] w_src_arr [N_REQ];
  logic [NODE_W-1:0] w_dst_arr [N_REQ];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .i_req (bus.req_valid),
    .i_ptr (r_rr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_src_arr[gi] = bus.req_src[gi*NODE_W +: NODE_W];
    assign w_dst_arr[gi] = bus.req_dst[gi*NODE_W +: NODE_W];
  end

  assign w_any       = |w_arb_gnt;
  assign w_cur_valid = bus.req_valid[r_gnt];
  assign w_cur_last  = bus.req_last[r_gnt];
  assign w_accept    = (r_state == ST_STREAM) && w_cur_valid;

  always_comb begin
    w_req_ready = '0;
    if (r_state == ST_STREAM) begin
      w_req_ready[r_gnt] = 1'b1;
    end
  end

  // A granted requester dropping valid mid-stream ends the job just like req_last.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_any) w_state_nxt = ST_STREAM;
      ST_STREAM: if (!w_cur_valid || w_cur_last) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (bus.eng_out_valid) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_gnt          <= '0;
      r_rr           <= '0;
      r_lat          <= '0;
      r_eng_in_valid <= 1'b0;
      r_eng_src      <= '0;
      r_eng_dst      <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_cost     <= '0;
      r_rsp_lat      <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_eng_in_valid <= w_accept;
      r_rsp_valid    <= 1'b0;
      if (w_accept) begin
        r_eng_src <= w_src_arr[r_gnt];
        r_eng_dst <= w_dst_arr[r_gnt];
      end
      if (bus.eng_out_valid && (r_state != ST_WAIT)) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt <= w_arb_idx;
            r_lat <= '0;
          end
        end
        ST_STREAM, ST_WAIT: begin
          if (!(&r_lat)) r_lat <= r_lat + 1'b1;
        end
        default: ;
      endcase
      if ((r_state == ST_WAIT) && bus.eng_out_valid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_gnt;
        r_rsp_cost  <= bus.eng_cost;
        r_rsp_lat   <= r_lat;
        r_rr        <= (r_gnt == ID_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
      end
    end
  end

  assign bus.req_ready       = w_req_ready;
  assign bus.eng_in_valid    = r_eng_in_valid;
  assign bus.eng_source      = r_eng_src;
  assign bus.eng_destination = r_eng_dst;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_id          = r_rsp_id;
  assign bus.rsp_cost        = r_rsp_cost;
  assign bus.rsp_latency     = r_rsp_lat;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.err_spurious    = r_err;

endmodule

// File: tb/tb_tt_query_arbiter.sv
// Directed bench for tt_query_arbiter: each task drives one scenario cycle by cycle
// and compares outputs against hand-derived values.
module tb_tt_query_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tt_query_arbiter_if #(.N_REQ(4), .LAT_W(8)) bus ();

  tt_query_arbiter #(
    .N_REQ (4),
    .ID_W  (2),
    .LAT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid     = '0;
    bus.req_last      = '0;
    bus.req_src       = '0;
    bus.req_dst       = '0;
    bus.eng_out_valid = 1'b0;
    bus.eng_cost      = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [29:0] all_outs();
    return {bus.req_ready, bus.eng_in_valid, bus.eng_source, bus.eng_destination,
            bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency, bus.busy,
            bus.err_spurious};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    n_chk++; if (all_outs() !== 30'd0) begin n_fail++;
      $display("FAIL rst_async: outs=%h want 0", all_outs()); end
    step();
    step();
    rst_n = 1'b1;
    n_chk++; if (all_outs() !== 30'd0) begin n_fail++;
      $display("FAIL rst_release: outs=%h want 0", all_outs()); end
    step();
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_idle_busy: busy=%b want 0", bus.busy); end
  endtask

  // req0: header (0,3), edges (0,1), (1,3)+last; engine answers 4 cycles after its last input.
  task automatic test_single_job();
    bus.req_valid[0] = 1'b1; bus.req_src[3:0] = 4'd0; bus.req_dst[3:0] = 4'd3;
    n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL sj_idle_ready: got %b want 0000", bus.req_ready); end
    step();
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL sj_grant_ready: got %b want 0001", bus.req_ready); end
    n_chk++; if (bus.eng_in_valid !== 1'b0) begin n_fail++;
      $display("FAIL sj_no_early_fwd: eng_in_valid=%b want 0", bus.eng_in_valid); end
    step();
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h103) begin
      n_fail++; $display("FAIL sj_fwd_hdr: got %h want 103",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    bus.req_src[3:0] = 4'd0; bus.req_dst[3:0] = 4'd1;
    step();
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h101) begin
      n_fail++; $display("FAIL sj_fwd_e1: got %h want 101",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    bus.req_src[3:0] = 4'd1; bus.req_dst[3:0] = 4'd3; bus.req_last[0] = 1'b1;
    step();
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h113) begin
      n_fail++; $display("FAIL sj_fwd_e2: got %h want 113",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL sj_wait_ready: got %b want 0000", bus.req_ready); end
    bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
    step();
    n_chk++; if (bus.eng_in_valid !== 1'b0) begin n_fail++;
      $display("FAIL sj_fwd_drop: eng_in_valid=%b want 0", bus.eng_in_valid); end
    step();
    step();
    step();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL sj_no_early_rsp: rsp_valid=%b want 0", bus.rsp_valid); end
    bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd2;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency} !== 15'h4207) begin
      n_fail++; $display("FAIL sj_rsp: got %h want 4207",
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency}); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL sj_busy_after: busy=%b want 0", bus.busy); end
    step();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL sj_rsp_pulse: rsp_valid=%b want 0", bus.rsp_valid); end
  endtask

  // After reset req1 and req3 request together, req0 joins during req1's job: order 1, 3, 0.
  task automatic test_round_robin();
    apply_reset();
    bus.req_valid = 4'b1010; bus.req_last = 4'b1010;
    bus.req_src = 16'h3010; bus.req_dst = 16'hC0A0;
    n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL rr_idle_ready: got %b want 0000", bus.req_ready); end
    step();
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++;
      $display("FAIL rr_first_g1: got %b want 0010", bus.req_ready); end
    bus.req_valid[0] = 1'b1; bus.req_last[0] = 1'b1;
    step();
    n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL rr_wait1_ready: got %b want 0000", bus.req_ready); end
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h11A) begin
      n_fail++; $display("FAIL rr_fwd1: got %h want 11a",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    bus.req_valid[1] = 1'b0; bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd5;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency} !== 15'h5501) begin
      n_fail++; $display("FAIL rr_rsp1: got %h want 5501",
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency}); end
    step();
    n_chk++; if (bus.req_ready !== 4'b1000) begin n_fail++;
      $display("FAIL rr_second_g3: got %b want 1000", bus.req_ready); end
    step();
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h13C) begin
      n_fail++; $display("FAIL rr_fwd3: got %h want 13c",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    bus.req_valid[3] = 1'b0; bus.eng_out_valid = 1'b1;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency} !== 15'h7501) begin
      n_fail++; $display("FAIL rr_rsp3: got %h want 7501",
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency}); end
    step();
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL rr_third_g0: got %b want 0001", bus.req_ready); end
    step();
    bus.req_valid[0] = 1'b0; bus.eng_out_valid = 1'b1;
    step();
    bus.eng_out_valid = 1'b0; bus.req_last = '0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency} !== 15'h4501) begin
      n_fail++; $display("FAIL rr_rsp0: got %h want 4501",
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency}); end
    n_chk++; if (bus.err_spurious !== 1'b0) begin n_fail++;
      $display("FAIL rr_no_spurious: err=%b want 0", bus.err_spurious); end
  endtask

  // req2: header (5,9), edge (5,6)+last; engine reports cost 0 (unreachable).
  task automatic test_unreachable();
    bus.req_valid[2] = 1'b1; bus.req_src[11:8] = 4'd5; bus.req_dst[11:8] = 4'd9;
    step();
    n_chk++; if (bus.req_ready !== 4'b0100) begin n_fail++;
      $display("FAIL ur_grant: got %b want 0100", bus.req_ready); end
    step();
    bus.req_dst[11:8] = 4'd6; bus.req_last[2] = 1'b1;
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h159) begin
      n_fail++; $display("FAIL ur_fwd_hdr: got %h want 159",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    step();
    bus.req_valid[2] = 1'b0; bus.req_last[2] = 1'b0;
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h156) begin
      n_fail++; $display("FAIL ur_fwd_edge: got %h want 156",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd0;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency} !== 15'h6002) begin
      n_fail++; $display("FAIL ur_rsp: got %h want 6002",
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency}); end
  endtask

  // req0 sends header + one edge, then drops valid without ever raising last.
  task automatic test_short_stream();
    bus.req_valid[0] = 1'b1; bus.req_src[3:0] = 4'd2; bus.req_dst[3:0] = 4'd7;
    step();
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL ss_grant: got %b want 0001", bus.req_ready); end
    step();
    bus.req_dst[3:0] = 4'd4;
    step();
    bus.req_valid[0] = 1'b0;
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h124) begin
      n_fail++; $display("FAIL ss_fwd_edge: got %h want 124",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    step();
    n_chk++; if ({bus.eng_in_valid, bus.req_ready, bus.busy} !== 6'b0_0000_1) begin n_fail++;
      $display("FAIL ss_wait: in_valid/ready/busy=%b want 000001",
               {bus.eng_in_valid, bus.req_ready, bus.busy}); end
    bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd6;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency} !== 15'h4603) begin
      n_fail++; $display("FAIL ss_rsp: got %h want 4603",
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency}); end
  endtask

  // Engine pulse while IDLE: flag is set and sticky, no response, later job still completes.
  task automatic test_spurious();
    bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd9;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.err_spurious, bus.rsp_valid} !== 2'b10) begin n_fail++;
      $display("FAIL sp_flag: err/rsp_valid=%b want 10", {bus.err_spurious, bus.rsp_valid}); end
    step();
    n_chk++; if (bus.err_spurious !== 1'b1) begin n_fail++;
      $display("FAIL sp_sticky: err=%b want 1", bus.err_spurious); end
    bus.req_valid[3] = 1'b1; bus.req_last[3] = 1'b1;
    bus.req_src[15:12] = 4'd4; bus.req_dst[15:12] = 4'd8;
    step();
    n_chk++; if (bus.req_ready !== 4'b1000) begin n_fail++;
      $display("FAIL sp_grant: got %b want 1000", bus.req_ready); end
    step();
    bus.req_valid[3] = 1'b0; bus.req_last[3] = 1'b0;
    n_chk++; if ({bus.eng_in_valid, bus.eng_source, bus.eng_destination} !== 9'h148) begin
      n_fail++; $display("FAIL sp_fwd: got %h want 148",
                         {bus.eng_in_valid, bus.eng_source, bus.eng_destination}); end
    bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd3;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency} !== 15'h7301) begin
      n_fail++; $display("FAIL sp_rsp: got %h want 7301",
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_cost, bus.rsp_latency}); end
    n_chk++; if (bus.err_spurious !== 1'b1) begin n_fail++;
      $display("FAIL sp_sticky_end: err=%b want 1", bus.err_spurious); end
  endtask

  // rr is left at 3 by a req2 job, then reset hits during req0's WAIT.
  // Afterwards req2 and req3 request together: a cleared rr picks 2.
  task automatic test_reset_mid_job();
    bus.req_valid[2] = 1'b1; bus.req_last[2] = 1'b1;
    step();
    step();
    bus.req_valid[2] = 1'b0; bus.req_last[2] = 1'b0;
    bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd7;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id} !== 3'b110) begin n_fail++;
      $display("FAIL rm_pre_rsp: valid/id=%b want 110", {bus.rsp_valid, bus.rsp_id}); end
    bus.req_valid[0] = 1'b1; bus.req_last[0] = 1'b1;
    bus.req_src[3:0] = 4'd3; bus.req_dst[3:0] = 4'd5;
    step();
    step();
    bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
    n_chk++; if ({bus.busy, bus.eng_in_valid} !== 2'b11) begin n_fail++;
      $display("FAIL rm_in_wait: busy/in_valid=%b want 11", {bus.busy, bus.eng_in_valid}); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (all_outs() !== 30'd0) begin n_fail++;
      $display("FAIL rm_outs_zero: outs=%h want 0", all_outs()); end
    #1;
    rst_n = 1'b1;
    bus.eng_out_valid = 1'b1; bus.eng_cost = 4'd4;
    step();
    bus.eng_out_valid = 1'b0;
    n_chk++; if ({bus.err_spurious, bus.rsp_valid} !== 2'b10) begin n_fail++;
      $display("FAIL rm_late_pulse: err/rsp_valid=%b want 10",
               {bus.err_spurious, bus.rsp_valid}); end
    bus.req_valid = 4'b1100; bus.req_last = 4'b1100;
    step();
    n_chk++; if (bus.req_ready !== 4'b0100) begin n_fail++;
      $display("FAIL rm_rr_cleared: got %b want 0100", bus.req_ready); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_unreachable();
    test_short_stream();
    test_spurious();
    test_reset_mid_job();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
